// File: rtl/alu_data_mem.sv
// Load/store data-memory endpoint: 1 KiB little-endian word RAM behind an IDLE/ACCESS/RESP controller.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned/illegal requests are trapped instead of force-aligned.
module alu_data_mem #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 2**(ADDR_W-2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                q_we;
  logic                q_unsigned;
  logic [1:0]          q_size;
  logic [ADDR_W-1:0]   q_addr;
  logic [DATA_W-1:0]   q_wdata;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];
  logic [DATA_W-1:0]   mem_q;

  logic [1:0]          eff_size;
  logic [ADDR_W-1:0]   eff_addr;
  logic                req_err;
  logic [3:0]          lane_en;
  logic [DATA_W-1:0]   lane_data;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_data;

  assign busy = ~req_ready;

  // Request decode works on the latched copy, which stays stable through ACCESS and RESP.
  always_comb begin
    eff_size = q_size;
    eff_addr = q_addr;
    req_err  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (q_size)
      2'b01:   req_err = q_addr[0];
      2'b10:   req_err = |q_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
`else
    if (q_size == 2'b11) eff_size = 2'b10;
    if (eff_size == 2'b01)      eff_addr[0]   = 1'b0;
    else if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    lane_en   = '0;
    lane_data = q_wdata;
    case (eff_size)
      2'b00: begin
        lane_en   = 4'b0001 << eff_addr[1:0];
        lane_data = {4{q_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = eff_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{q_wdata[15:0]}};
      end
      default: lane_en = 4'b1111;
    endcase
    if (req_err) lane_en = '0;
  end

  always_comb begin
    byte_sel  = mem_q[{eff_addr[1:0], 3'b000} +: 8];
    half_sel  = eff_addr[1] ? mem_q[31:16] : mem_q[15:0];
    load_data = mem_q;
    case (eff_size)
      2'b00:   load_data = q_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = q_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = mem_q;
    endcase
    if (q_we || req_err) load_data = '0;
  end

  // RAM has no reset; an async reset pulls state out of ACCESS, which suppresses the write.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (q_we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (lane_en[i]) mem[eff_addr[ADDR_W-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
      mem_q <= mem[eff_addr[ADDR_W-1:2]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rdata      <= '0;
      misalign   <= 1'b0;
      q_we       <= 1'b0;
      q_unsigned <= 1'b0;
      q_size     <= '0;
      q_addr     <= '0;
      q_wdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            q_we       <= req_we;
            q_unsigned <= req_unsigned;
            q_size     <= req_size;
            q_addr     <= addr;
            q_wdata    <= wdata;
            req_ready  <= 1'b0;
            state      <= ACCESS;
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          rsp_valid <= 1'b1;
          rdata     <= load_data;
          misalign  <= req_err;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
